mfp_ahb_sevenseg_scan: RTL and testbench
========================================

Name: mfp_ahb_sevenseg_scan

Overview:
- Time-multiplexed scan controller for the 8-digit seven-segment display.
- Sits directly upstream of the seven-segment decoder.
- Each digit period, drives one active-low anode and presents a 6-bit code {dp_n, char[4:0]} to the decoder data input.
- Inputs come from the AHB GPIO/display register block. Values are snapshotted once per frame so a frame never mixes old and new digits.

Parameters:
- REFRESH_DIV, 50000: SHOW-state cycles per digit (1 kHz per digit at 50 MHz); legal range 2..65535.
- BLANK_CYCLES, 500: guard-interval cycles per digit; used only with the optional feature; legal range 1..65535.

Ports:
- HCLK  input  1  system clock; all state changes on rising edge.
- HRESETn  input  1  reset, asynchronous assert, active-low.
- EN  input  8  digit enable; bit i=1 lights digit i.
- DIGITS  input  40  character codes; digit i = DIGITS[5i+4:5i]; codes 0-27 valid, others decode blank.
- DP  input  8  decimal point; bit i=1 lights dp of digit i.
- AN  output  8  anode select, active-low; at most one bit low.
- CODE  output  6  to decoder data: CODE[5]=~dp (active-low), CODE[4:0]=char.
- FRAME_TICK  output  1  one-cycle pulse when the scan wraps from digit 7 to digit 0.

Behaviour:
- Reset values (async, HRESETn=0):
  - AN=8'hFF, CODE=6'h3F, FRAME_TICK=0.
  - Prescaler=0, digit index idx=0, snapshot regs (EN_s, DIGITS_s, DP_s)=0, state=INIT.
- States: INIT, SHOW, GUARD. GUARD is reachable only with the macro.
- INIT (exactly one cycle after reset release):
  - Load snapshot from EN/DIGITS/DP.
  - Go to SHOW with idx=0, prescaler=0.
- Outputs are registered and updated on the same edge that enters SHOW or changes idx.
- In SHOW with digit i:
  - If EN_s[i]=1: AN=~(8'b1<<i), CODE={~DP_s[i], DIGITS_s[5i+4:5i]}.
  - If EN_s[i]=0: AN=8'hFF, CODE=6'h3F.
- Prescaler counts 0..REFRESH_DIV-1 in SHOW. A digit is shown for exactly REFRESH_DIV cycles.
- Terminal count without macro:
  - idx <= idx+1 mod 8, prescaler <= 0, outputs update to the new digit on the same edge.
- Wrap (idx 7->0):
  - On the same edge, snapshot reloads from the live inputs, and digit 0 is displayed using the new snapshot.
  - FRAME_TICK=1 for exactly that one cycle.
- Live input changes mid-frame never affect AN/CODE until the next wrap.
- Frame period without macro: 8*REFRESH_DIV cycles.
- Reset mid-scan: outputs go blank immediately (asynchronous), the sequence restarts at INIT, and no FRAME_TICK is emitted.
- Invariant: AN never has more than one bit low, in any cycle.

Optional Feature:
- Macro: MFP_SEVENSEG_GHOST_BLANK_EN.
- With the macro:
  - At SHOW terminal count, enter GUARD for BLANK_CYCLES cycles with AN=8'hFF, CODE=6'h3F; idx unchanged.
  - At GUARD end, advance idx (wrap/snapshot/FRAME_TICK rules as above) and enter SHOW for the new digit.
  - Digit period = REFRESH_DIV+BLANK_CYCLES cycles; frame = 8*(REFRESH_DIV+BLANK_CYCLES).
  - Purpose: removes ghosting from anode/segment skew.
- Without the macro: GUARD state and the BLANK_CYCLES counter are not synthesized, and behaviour is as described in Behaviour.

Test Plan (bench uses REFRESH_DIV=4, BLANK_CYCLES=2):
- Reset then release; EN=8'hFF, DIGITS={8 codes 7..0}, DP=8'h01.
  - Cycle 1 after release: AN=FF.
  - Then AN=8'hFE, CODE=6'h00 for 4 cycles, then AN=8'hFD, CODE=6'h21.
  - Eighth digit AN=8'h7F, CODE=6'h27.
  - FRAME_TICK pulses every 32 cycles.
- EN=8'h05:
  - Only AN=FE and AN=FB are ever driven low.
  - Other digit slots show AN=FF, CODE=3F.
  - AN is never multi-hot, checked every cycle.
- Change DIGITS[4:0] from 5'd3 to 5'd9 while digit 3 is shown:
  - CODE for digit 0 stays 6'h23 until the FRAME_TICK cycle, then 6'h29.
- DIGITS slot = 5'd31 (invalid) with EN bit set:
  - CODE[4:0]=5'd31 is passed through.
  - The decoder output is blank segments, with dp per DP.
- Assert HRESETn=0 asynchronously mid-cycle while AN=F7:
  - AN=FF and CODE=3F before the next HCLK edge.
  - After release, the scan restarts at digit 0 after the INIT cycle.
- With MFP_SEVENSEG_GHOST_BLANK_EN:
  - Each digit shows 4 cycles followed by 2 cycles of AN=FF.
  - FRAME_TICK period is 48 cycles.
  - idx changes only at GUARD exit.

Source files
------------

// File: rtl/mfp_ahb_sevenseg_scan.sv
// Time-multiplexed scan controller for the 8-digit seven-segment display.
// Drives one active-low anode per digit period and presents {dp_n, char}
// to the downstream decoder. Inputs are snapshotted once per frame.
// Optional feature macro: MFP_SEVENSEG_GHOST_BLANK_EN inserts a blanking
// guard interval of BLANK_CYCLES after every digit to suppress ghosting.
module mfp_ahb_sevenseg_scan #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [7:0]  EN,
    input  logic [39:0] DIGITS,
    input  logic [7:0]  DP,
    output logic [7:0]  AN,
    output logic [5:0]  CODE,
    output logic        FRAME_TICK
);

    localparam logic [15:0] SHOW_LAST = 16'(REFRESH_DIV - 1);

    // Parameter legality is checked at elaboration so a bad build fails early
    if (REFRESH_DIV < 2 || REFRESH_DIV > 65535) begin : g_bad_refresh_div
        $error("REFRESH_DIV must be in 2..65535");
    end
    if (BLANK_CYCLES < 1 || BLANK_CYCLES > 65535) begin : g_bad_blank_cycles
        $error("BLANK_CYCLES must be in 1..65535");
    end

`ifdef MFP_SEVENSEG_GHOST_BLANK_EN
    localparam logic [15:0] GUARD_LAST = 16'(BLANK_CYCLES - 1);
    typedef enum logic [1:0] {INIT, SHOW, GUARD} state_t;
`else
    typedef enum logic [1:0] {INIT, SHOW} state_t;
`endif

    state_t      state, state_d;
    logic [15:0] presc, presc_d;
    logic [2:0]  idx, idx_d, idx_inc;
    logic [7:0]  en_s, en_s_d;
    logic [39:0] digits_s, digits_s_d;
    logic [7:0]  dp_s, dp_s_d;
    logic [7:0]  an_d;
    logic [5:0]  code_d;
    logic        tick_d;
    logic        advance;
`ifdef MFP_SEVENSEG_GHOST_BLANK_EN
    logic [15:0] guard_cnt, guard_cnt_d;
`endif

    // Anode and code for digit i, or a blank slot when the digit is disabled
    function automatic logic [13:0] digit_out(
        input logic [7:0]  en,
        input logic [39:0] digits,
        input logic [7:0]  dp,
        input logic [2:0]  i
    );
        logic [4:0] ch;
        ch = 5'd0;
        for (int k = 0; k < 8; k++) begin
            if (3'(k) == i) ch = digits[5*k +: 5];
        end
        if (en[i]) return {~(8'b1 << i), ~dp[i], ch};
        else       return {8'hFF, 6'h3F};
    endfunction

    assign idx_inc = idx + 3'd1;

    // Next-state logic: prescaling, digit advance, frame wrap and snapshot reload
    always_comb begin
        state_d    = state;
        presc_d    = presc;
        idx_d      = idx;
        en_s_d     = en_s;
        digits_s_d = digits_s;
        dp_s_d     = dp_s;
        an_d       = AN;
        code_d     = CODE;
        tick_d     = 1'b0;
        advance    = 1'b0;
`ifdef MFP_SEVENSEG_GHOST_BLANK_EN
        guard_cnt_d = guard_cnt;
`endif
        case (state)
            INIT: begin
                en_s_d           = EN;
                digits_s_d       = DIGITS;
                dp_s_d           = DP;
                idx_d            = 3'd0;
                presc_d          = 16'd0;
                state_d          = SHOW;
                {an_d, code_d}   = digit_out(EN, DIGITS, DP, 3'd0);
            end
            SHOW: begin
                if (presc == SHOW_LAST) begin
                    presc_d = 16'd0;
`ifdef MFP_SEVENSEG_GHOST_BLANK_EN
                    state_d     = GUARD;
                    guard_cnt_d = 16'd0;
                    an_d        = 8'hFF;
                    code_d      = 6'h3F;
`else
                    advance = 1'b1;
`endif
                end else begin
                    presc_d = presc + 16'd1;
                end
            end
`ifdef MFP_SEVENSEG_GHOST_BLANK_EN
            GUARD: begin
                if (guard_cnt == GUARD_LAST) begin
                    advance = 1'b1;
                    state_d = SHOW;
                end else begin
                    guard_cnt_d = guard_cnt + 16'd1;
                end
            end
`endif
            default: state_d = INIT;
        endcase

        if (advance) begin
            idx_d = idx_inc;
            if (idx == 3'd7) begin
                en_s_d         = EN;
                digits_s_d     = DIGITS;
                dp_s_d         = DP;
                tick_d         = 1'b1;
                {an_d, code_d} = digit_out(EN, DIGITS, DP, 3'd0);
            end else begin
                {an_d, code_d} = digit_out(en_s, digits_s, dp_s, idx_inc);
            end
        end
    end

    // State, snapshot and registered outputs; reset blanks the display at once
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= INIT;
            presc      <= 16'd0;
            idx        <= 3'd0;
            en_s       <= 8'd0;
            digits_s   <= 40'd0;
            dp_s       <= 8'd0;
            AN         <= 8'hFF;
            CODE       <= 6'h3F;
            FRAME_TICK <= 1'b0;
        end else begin
            state      <= state_d;
            presc      <= presc_d;
            idx        <= idx_d;
            en_s       <= en_s_d;
            digits_s   <= digits_s_d;
            dp_s       <= dp_s_d;
            AN         <= an_d;
            CODE       <= code_d;
            FRAME_TICK <= tick_d;
        end
    end

`ifdef MFP_SEVENSEG_GHOST_BLANK_EN
    // Guard-interval counter, only present when blanking is built in
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) guard_cnt <= 16'd0;
        else          guard_cnt <= guard_cnt_d;
    end
`endif

endmodule

// File: tb/tb_mfp_ahb_sevenseg_scan.sv
// Self-checking bench for mfp_ahb_sevenseg_scan (REFRESH_DIV=4, BLANK_CYCLES=2).
// Expected per-cycle outputs are pushed to a queue by the driver and popped
// by an independent monitor on the falling clock edge.
module tb_mfp_ahb_sevenseg_scan;

    localparam int RDIV  = 4;
    localparam int BLANK = 2;
`ifdef MFP_SEVENSEG_GHOST_BLANK_EN
    localparam int SLOT = RDIV + BLANK;
`else
    localparam int SLOT = RDIV;
`endif
    localparam int FRAME = 8 * SLOT;

    logic        HCLK;
    logic        HRESETn;
    logic [7:0]  EN;
    logic [39:0] DIGITS;
    logic [7:0]  DP;
    logic [7:0]  AN;
    logic [5:0]  CODE;
    logic        FRAME_TICK;

    int checks   = 0;
    int failures = 0;

    logic [14:0] exp_q[$];
    logic [63:0] cur_an, pend_an;
    logic [47:0] cur_code, pend_code;
    int          scan_pos;

    mfp_ahb_sevenseg_scan #(.REFRESH_DIV(RDIV), .BLANK_CYCLES(BLANK)) dut (
        .HCLK(HCLK),
        .HRESETn(HRESETn),
        .EN(EN),
        .DIGITS(DIGITS),
        .DP(DP),
        .AN(AN),
        .CODE(CODE),
        .FRAME_TICK(FRAME_TICK)
    );

    // 100 MHz clock
    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, required, $time);
        end
    endtask

    // Drive live inputs and record the hand-computed tables they should produce
    task automatic applyStimulus(input logic [7:0] en, input logic [39:0] digits, input logic [7:0] dp,
                                 input logic [63:0] an_tab, input logic [47:0] code_tab);
        EN        = en;
        DIGITS    = digits;
        DP        = dp;
        pend_an   = an_tab;
        pend_code = code_tab;
    endtask

    // One scan cycle: the snapshot tables switch over only at a frame wrap
    task automatic stepCycle();
        int   digit;
        int   p;
        logic tick;
        @(posedge HCLK);
        #1;
        tick = 1'b0;
        if (scan_pos % FRAME == 0 && scan_pos != 0) begin
            cur_an   = pend_an;
            cur_code = pend_code;
            tick     = 1'b1;
        end
        digit = (scan_pos % FRAME) / SLOT;
        p     = scan_pos % SLOT;
        if (p < RDIV) exp_q.push_back({cur_an[8*digit +: 8], cur_code[6*digit +: 6], tick});
        else          exp_q.push_back({8'hFF, 6'h3F, tick});
        scan_pos++;
    endtask

    task automatic runTo(input int target);
        while (scan_pos % FRAME != target) stepCycle();
    endtask

    // Release reset; the following cycle is the blank INIT cycle
    task automatic startAfterReset();
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        exp_q.push_back({8'hFF, 6'h3F, 1'b0});
        cur_an   = pend_an;
        cur_code = pend_code;
        scan_pos = 0;
    endtask

    // Monitor: pops expectations and checks the one-cold anode invariant every cycle
    always @(negedge HCLK) begin
        logic [14:0] e;
        if (HRESETn === 1'b1) begin
            checkOutput("an_onehot", {31'd0, ($countones(~AN) <= 1)}, 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("scan_out", {17'd0, AN, CODE, FRAME_TICK}, {17'd0, e});
            end
        end
    end

    // Watchdog so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        HRESETn  = 1'b0;
        scan_pos = 0;
        cur_an   = '1;
        cur_code = '1;
        applyStimulus(8'hFF, {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0}, 8'h01,
                      64'h7FBF_DFEF_F7FB_FDFE,
                      {6'h27, 6'h26, 6'h25, 6'h24, 6'h23, 6'h22, 6'h21, 6'h00});
        repeat (2) @(posedge HCLK);
        #1;
        checkOutput("reset_an",   {24'd0, AN},   32'h0000_00FF);
        checkOutput("reset_code", {26'd0, CODE}, 32'h0000_003F);
        checkOutput("reset_tick", {31'd0, FRAME_TICK}, 32'd0);

        // All digits enabled, dp on digit 0 only
        startAfterReset();
        repeat (2 * FRAME) stepCycle();

        // Only digits 0 and 2 enabled; changed mid-frame, visible after next wrap
        repeat (10) stepCycle();
        applyStimulus(8'h05, {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd3}, 8'h00,
                      64'hFFFF_FFFF_FFFB_FFFE,
                      {6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h22, 6'h3F, 6'h23});
        repeat (2 * FRAME) stepCycle();

        // Digit 0 char 3 -> 9 while digit 3 is being scanned
        runTo(3 * SLOT + 1);
        applyStimulus(8'h05, {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd9}, 8'h00,
                      64'hFFFF_FFFF_FFFB_FFFE,
                      {6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h22, 6'h3F, 6'h29});
        repeat (FRAME + 8) stepCycle();

        // Invalid code 31 on enabled digit 2 passes through, with its dp lit
        repeat (5) stepCycle();
        applyStimulus(8'h05, {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd31, 5'd1, 5'd9}, 8'h04,
                      64'hFFFF_FFFF_FFFB_FFFE,
                      {6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h1F, 6'h3F, 6'h29});
        repeat (FRAME + 4) stepCycle();

        // All digits on again, then reset asynchronously while digit 3 is lit
        applyStimulus(8'hFF, {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd31, 5'd1, 5'd9}, 8'h04,
                      64'h7FBF_DFEF_F7FB_FDFE,
                      {6'h27, 6'h26, 6'h25, 6'h24, 6'h23, 6'h1F, 6'h21, 6'h29});
        runTo(0);
        runTo(3 * SLOT + 1);
        @(posedge HCLK);
        #1;
        checkOutput("pre_reset_an", {24'd0, AN}, 32'h0000_00F7);
        #1;
        HRESETn = 1'b0;
        #1;
        checkOutput("async_reset_an",   {24'd0, AN},   32'h0000_00FF);
        checkOutput("async_reset_code", {26'd0, CODE}, 32'h0000_003F);
        checkOutput("async_reset_tick", {31'd0, FRAME_TICK}, 32'd0);

        // Restart from INIT and digit 0 with no spurious tick
        startAfterReset();
        repeat (FRAME + SLOT + 2) stepCycle();

        repeat (2) @(negedge HCLK);
        #1;
        checkOutput("queue_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
